sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM controller command/read-data port between two requesters.
  - Video line prefetcher: high priority, burst reads.
  - Host port: single-word reads and writes.
- Sits between the VGA scanline fetch logic (driven by hvsync_generator timing) and the SDRAM controller, in the clk_100mhz domain.
- Serialises transactions: one outstanding command at a time, read beats routed back to the owner.

---
 rtl/vga_sdram_pkg.sv | 34 +++
 rtl/sdram_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sdram_pkg.sv
// vga_sdram_pkg
//   Shared types and helpers for the SDRAM port arbiter.
//   - DEF_ADDR_W / DEF_DATA_W : default SDRAM word address / data widths
//   - state_e                 : arbiter FSM state encoding
//   - owner_e                 : which requester owns the current transaction
//   - arb_pick()              : arbitration priority between video and host
package vga_sdram_pkg;

   localparam int unsigned DEF_ADDR_W = 24;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA
   } state_e;

   typedef enum logic {
      OWN_VID,
      OWN_HOST
   } owner_e;

   // Video wins unless host is the only requester or the starvation
   // guard forces a host turn. Only meaningful when some request is high.
   function automatic owner_e arb_pick(input logic vid_req,
                                       input logic host_req,
                                       input logic host_forced);
      if (host_req && (host_forced || !vid_req)) begin
         return OWN_HOST;
      end
      return OWN_VID;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single SDRAM controller command / read-data port between the
//   video line prefetcher (high priority, BURST_LEN-word burst reads) and the
//   host port (single-word reads and writes). One command is outstanding at
//   a time; read beats are registered and routed back to the owner.
//
//   Ports
//     clk, reset                     : clock, synchronous active-high reset
//     vid_req/vid_addr               : video burst-read request and address
//     vid_gnt/vid_rvalid/vid_rdata/vid_done : video grant, beats, completion
//     host_req/host_we/host_addr/host_wdata : host access request
//     host_gnt/host_rvalid/host_rdata/host_done : host grant, beat, completion
//     mem_cmd_*                      : command to SDRAM controller (valid/ready)
//     mem_rvalid/mem_rdata           : read beats from SDRAM controller
//
//   Build option
//     ARB_STARVE_GUARD_EN : after MAX_VID_RUN consecutive video grants issued
//                           while the host waits, the host gets the next turn.
module sdram_port_arbiter
   import vga_sdram_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned BURST_LEN   = 8,
   parameter int unsigned LEN_W       = 4,
   parameter int unsigned MAX_VID_RUN = 4
) (
   input  logic              clk,
   input  logic              reset,
   // video prefetcher
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_done,
   // host port
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_done,
   // SDRAM controller
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_we,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic [LEN_W-1:0]  mem_cmd_len,
   output logic [DATA_W-1:0] mem_cmd_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e              r_state;
   state_e              w_next_state;
   owner_e              r_owner;
   owner_e              w_pick;
   logic [LEN_W-1:0]    r_beats;

   logic                r_cmd_we;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic [LEN_W-1:0]    r_cmd_len;
   logic [DATA_W-1:0]   r_cmd_wdata;

   logic                r_vid_rvalid;
   logic [DATA_W-1:0]   r_vid_rdata;
   logic                r_vid_done;
   logic                r_host_rvalid;
   logic [DATA_W-1:0]   r_host_rdata;
   logic                r_host_rd_done;

   logic                w_any_req;
   logic                w_accept;
   logic                w_beat;
   logic                w_last;
   logic                w_force_host;

   assign w_any_req = vid_req | host_req;
   assign w_accept  = (r_state == ST_CMD) & mem_cmd_ready;
   assign w_beat    = (r_state == ST_DATA) & mem_rvalid;
   assign w_last    = w_beat & (r_beats == LEN_W'(1));
   assign w_pick    = arb_pick(vid_req, host_req, w_force_host);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_next_state = ST_CMD;
            end
         end
         ST_CMD: begin
            if (mem_cmd_ready) begin
               w_next_state = r_cmd_we ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_last) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Command latch: fields captured once in IDLE, held stable through CMD
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner     <= OWN_VID;
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_len   <= '0;
         r_cmd_wdata <= '0;
      end else if ((r_state == ST_IDLE) && w_any_req) begin
         r_owner <= w_pick;
         if (w_pick == OWN_VID) begin
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= vid_addr;
            r_cmd_len   <= LEN_W'(BURST_LEN);
            r_cmd_wdata <= '0;
         end else begin
            r_cmd_we    <= host_we;
            r_cmd_addr  <= host_addr;
            r_cmd_len   <= LEN_W'(1);
            r_cmd_wdata <= host_we ? host_wdata : '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Beat counter and read-data return path
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_beats        <= '0;
         r_vid_rvalid   <= 1'b0;
         r_vid_rdata    <= '0;
         r_vid_done     <= 1'b0;
         r_host_rvalid  <= 1'b0;
         r_host_rdata   <= '0;
         r_host_rd_done <= 1'b0;
      end else begin
         if (w_accept) begin
            r_beats <= r_cmd_len;
         end else if (w_beat) begin
            r_beats <= r_beats - LEN_W'(1);
         end

         r_vid_rvalid   <= w_beat & (r_owner == OWN_VID);
         r_vid_done     <= w_last & (r_owner == OWN_VID);
         r_host_rvalid  <= w_beat & (r_owner == OWN_HOST);
         r_host_rd_done <= w_last & (r_owner == OWN_HOST);

         if (w_beat && (r_owner == OWN_VID)) begin
            r_vid_rdata <= mem_rdata;
         end
         if (w_beat && (r_owner == OWN_HOST)) begin
            r_host_rdata <= mem_rdata;
         end
      end
   end

   // ------------------------------------------------------------------
   // Optional starvation guard
   // ------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned RUN_W = $clog2(MAX_VID_RUN + 1);

   logic [RUN_W-1:0] r_run;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_run <= '0;
      end else if (host_gnt) begin
         r_run <= '0;
      end else if ((r_state == ST_IDLE) && !host_req) begin
         r_run <= '0;
      end else if (vid_gnt && host_req && (r_run != RUN_W'(MAX_VID_RUN))) begin
         r_run <= r_run + RUN_W'(1);
      end
   end

   assign w_force_host = (r_run == RUN_W'(MAX_VID_RUN));
`else
   assign w_force_host = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Grants follow the accept handshake combinationally so the requester
   // sees the pulse in the same cycle the controller takes the command.
   assign mem_cmd_valid = (r_state == ST_CMD);
   assign mem_cmd_we    = r_cmd_we;
   assign mem_cmd_addr  = r_cmd_addr;
   assign mem_cmd_len   = r_cmd_len;
   assign mem_cmd_wdata = r_cmd_wdata;

   assign vid_gnt    = w_accept & (r_owner == OWN_VID);
   assign vid_rvalid = r_vid_rvalid;
   assign vid_rdata  = r_vid_rdata;
   assign vid_done   = r_vid_done;

   assign host_gnt    = w_accept & (r_owner == OWN_HOST);
   assign host_rvalid = r_host_rvalid;
   assign host_rdata  = r_host_rdata;
   // Writes complete on accept; reads complete with their returned beat.
   assign host_done   = (host_gnt & r_cmd_we) | r_host_rd_done;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed, table-driven bench for sdram_port_arbiter: a vector table of
//   single transactions plus hand-written sequences for arbitration,
//   reset mid-burst, stray controller strobes and the starvation guard.
module tb_sdram_port_arbiter;

   localparam int unsigned AW  = 24;
   localparam int unsigned DW  = 16;
   localparam int unsigned BL  = 8;
   localparam int unsigned LW  = 4;
   localparam int unsigned MVR = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_gnt;
   logic          vid_rvalid;
   logic [DW-1:0] vid_rdata;
   logic          vid_done;
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          host_done;
   logic          mem_cmd_valid;
   logic          mem_cmd_ready;
   logic          mem_cmd_we;
   logic [AW-1:0] mem_cmd_addr;
   logic [LW-1:0] mem_cmd_len;
   logic [DW-1:0] mem_cmd_wdata;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;

   sdram_port_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .BURST_LEN   (BL),
      .LEN_W       (LW),
      .MAX_VID_RUN (MVR)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .vid_req       (vid_req),
      .vid_addr      (vid_addr),
      .vid_gnt       (vid_gnt),
      .vid_rvalid    (vid_rvalid),
      .vid_rdata     (vid_rdata),
      .vid_done      (vid_done),
      .host_req      (host_req),
      .host_we       (host_we),
      .host_addr     (host_addr),
      .host_wdata    (host_wdata),
      .host_gnt      (host_gnt),
      .host_rvalid   (host_rvalid),
      .host_rdata    (host_rdata),
      .host_done     (host_done),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_ready (mem_cmd_ready),
      .mem_cmd_we    (mem_cmd_we),
      .mem_cmd_addr  (mem_cmd_addr),
      .mem_cmd_len   (mem_cmd_len),
      .mem_cmd_wdata (mem_cmd_wdata),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          is_vid;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int unsigned   dly;        // cycles of mem_cmd_ready low in CMD
      logic [LW-1:0] exp_len;
      logic [DW-1:0] exp_wdata;
      logic [DW-1:0] base;       // first read beat value
   } vec_t;

   localparam int unsigned NV = 5;
   vec_t vecs [NV];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then driven and
   // outputs sampled 1 time unit later, well away from either clock edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Entered in the IDLE cycle in which the request is presented; returns in
   // the cycle where mem_cmd_ready is high (the accept cycle).
   task automatic cmd_phase(input vec_t v);
      for (int unsigned k = 0; k <= v.dly; k++) begin
         cyc();
         mem_cmd_ready = (k == v.dly);
         #1;
         chk("cmd_valid", mem_cmd_valid, 1);
         chk("cmd_we",    mem_cmd_we, v.we);
         chk("cmd_addr",  mem_cmd_addr, v.addr);
         chk("cmd_len",   mem_cmd_len, v.exp_len);
         chk("cmd_wdata", mem_cmd_wdata, v.exp_wdata);
         chk("vid_gnt",   vid_gnt,  (k == v.dly) && v.is_vid);
         chk("host_gnt",  host_gnt, (k == v.dly) && !v.is_vid);
         chk("host_done_at_gnt", host_done, (k == v.dly) && !v.is_vid && v.we);
      end
   endtask

   // Entered in the accept cycle; feeds n beats back-to-back and returns in
   // the cycle where the owner's done pulse is expected (FSM back in IDLE).
   task automatic feed_beats(input logic vid, input int unsigned n,
                             input logic [DW-1:0] base, input logic drop);
      for (int unsigned i = 0; i <= n; i++) begin
         cyc();
         mem_cmd_ready = 1'b0;
         if (i == 0 && drop) begin
            if (vid) vid_req = 1'b0;
            else     host_req = 1'b0;
         end
         mem_rvalid = (i < n);
         mem_rdata  = base + DW'(i);
         #1;
         chk("own_rvalid", vid ? vid_rvalid : host_rvalid, (i > 0));
         if (i > 0) begin
            chk("own_rdata", vid ? vid_rdata : host_rdata, base + DW'(i - 1));
         end
         chk("own_done",   vid ? vid_done : host_done, (i == n));
         chk("oth_rvalid", vid ? host_rvalid : vid_rvalid, 0);
         chk("oth_done",   vid ? host_done : vid_done, 0);
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic do_txn(input vec_t v);
      cyc();
      if (v.is_vid) begin
         vid_req  = 1'b1;
         vid_addr = v.addr;
      end else begin
         host_req   = 1'b1;
         host_we    = v.we;
         host_addr  = v.addr;
         host_wdata = v.wdata;
      end
      #1;
      chk("idle_valid", mem_cmd_valid, 0);
      cmd_phase(v);
      if (v.we) begin
         cyc();
         mem_cmd_ready = 1'b0;
         host_req      = 1'b0;
         #1;
         chk("wr_post_done",   host_done, 0);
         chk("wr_post_gnt",    host_gnt, 0);
         chk("wr_post_valid",  mem_cmd_valid, 0);
         chk("wr_post_rvalid", host_rvalid, 0);
      end else begin
         feed_beats(v.is_vid, v.exp_len, v.base, 1'b1);
         cyc();
         #1;
         chk("rd_post_rvalid", v.is_vid ? vid_rvalid : host_rvalid, 0);
         chk("rd_post_done",   v.is_vid ? vid_done : host_done, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt;
      int unsigned n_vid;
      logic        host_won;
      logic        stuck;

      //            vid   we    addr        wdata    dly len    exp_wd   base
      vecs[0] = '{1'b1, 1'b0, 24'h000100, 16'h0000, 0, 4'd8, 16'h0000, 16'hA000};
      vecs[1] = '{1'b0, 1'b1, 24'h000020, 16'hBEEF, 3, 4'd1, 16'hBEEF, 16'h0000};
      vecs[2] = '{1'b0, 1'b0, 24'h000040, 16'h5555, 1, 4'd1, 16'h0000, 16'h1234};
      vecs[3] = '{1'b1, 1'b0, 24'hFFFFFF, 16'h0000, 2, 4'd8, 16'h0000, 16'hB000};
      vecs[4] = '{1'b0, 1'b1, 24'h000000, 16'hFFFF, 0, 4'd1, 16'hFFFF, 16'h0000};

      reset         = 1'b1;
      vid_req       = 1'b0;
      vid_addr      = '0;
      host_req      = 1'b0;
      host_we       = 1'b0;
      host_addr     = '0;
      host_wdata    = '0;
      mem_cmd_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;

      // ---- reset state ----
      repeat (3) cyc();
      chk("rst_cmd_valid",   mem_cmd_valid, 0);
      chk("rst_cmd_we",      mem_cmd_we, 0);
      chk("rst_cmd_addr",    mem_cmd_addr, 0);
      chk("rst_cmd_len",     mem_cmd_len, 0);
      chk("rst_cmd_wdata",   mem_cmd_wdata, 0);
      chk("rst_vid_gnt",     vid_gnt, 0);
      chk("rst_vid_rvalid",  vid_rvalid, 0);
      chk("rst_vid_rdata",   vid_rdata, 0);
      chk("rst_vid_done",    vid_done, 0);
      chk("rst_host_gnt",    host_gnt, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_host_rdata",  host_rdata, 0);
      chk("rst_host_done",   host_done, 0);
      reset = 1'b0;

      // ---- table of single transactions ----
      for (int i = 0; i < NV; i++) begin
         do_txn(vecs[i]);
      end

      // ---- simultaneous requests: video first, then host read ----
      cyc();
      vid_req    = 1'b1;
      vid_addr   = 24'h000300;
      host_req   = 1'b1;
      host_we    = 1'b0;
      host_addr  = 24'h000077;
      host_wdata = 16'h9999;
      #1;
      chk("sim_idle_valid", mem_cmd_valid, 0);
      vt = '{1'b1, 1'b0, 24'h000300, 16'h0000, 0, 4'd8, 16'h0000, 16'hC000};
      cmd_phase(vt);
      feed_beats(1'b1, 8, 16'hC000, 1'b1);
      chk("sim_valid_at_vdone", mem_cmd_valid, 0);
      vt = '{1'b0, 1'b0, 24'h000077, 16'h9999, 0, 4'd1, 16'h0000, 16'h1234};
      cmd_phase(vt);
      feed_beats(1'b0, 1, 16'h1234, 1'b1);
      cyc();
      #1;
      chk("sim_post_valid", mem_cmd_valid, 0);

      // ---- reset in the middle of a video burst ----
      cyc();
      vid_req  = 1'b1;
      vid_addr = 24'h000500;
      #1;
      vt = '{1'b1, 1'b0, 24'h000500, 16'h0000, 0, 4'd8, 16'h0000, 16'hD000};
      cmd_phase(vt);
      for (int i = 0; i < 4; i++) begin
         cyc();
         mem_cmd_ready = 1'b0;
         vid_req       = 1'b0;
         mem_rvalid    = 1'b1;
         mem_rdata     = 16'hD000 + DW'(i);
         reset         = (i == 3);
         #1;
      end
      cyc();
      reset     = 1'b0;
      mem_rdata = 16'hD004;
      #1;
      chk("mrst_vid_rvalid", vid_rvalid, 0);
      chk("mrst_vid_rdata",  vid_rdata, 0);
      chk("mrst_vid_done",   vid_done, 0);
      chk("mrst_vid_gnt",    vid_gnt, 0);
      chk("mrst_cmd_valid",  mem_cmd_valid, 0);
      chk("mrst_cmd_addr",   mem_cmd_addr, 0);
      chk("mrst_cmd_len",    mem_cmd_len, 0);
      chk("mrst_host_done",  host_done, 0);
      for (int i = 5; i < 9; i++) begin
         cyc();
         mem_rvalid = (i < 8);
         mem_rdata  = 16'hD000 + DW'(i);
         #1;
         chk("mrst_drop_rvalid", vid_rvalid, 0);
         chk("mrst_drop_done",   vid_done, 0);
      end
      vt = '{1'b1, 1'b0, 24'h000600, 16'h0000, 1, 4'd8, 16'h0000, 16'h7700};
      do_txn(vt);

      // ---- stray mem_rvalid and mem_cmd_ready while idle ----
      for (int i = 0; i < 3; i++) begin
         cyc();
         mem_rvalid    = 1'b1;
         mem_cmd_ready = 1'b1;
         mem_rdata     = 16'hEEEE;
         #1;
         chk("stray_vid_rvalid",  vid_rvalid, 0);
         chk("stray_host_rvalid", host_rvalid, 0);
         chk("stray_vid_gnt",     vid_gnt, 0);
         chk("stray_host_gnt",    host_gnt, 0);
         chk("stray_cmd_valid",   mem_cmd_valid, 0);
      end
      cyc();
      mem_rvalid    = 1'b0;
      mem_cmd_ready = 1'b0;
      #1;
      chk("stray_last_rvalid", vid_rvalid | host_rvalid, 0);
      chk("stray_last_done",   vid_done | host_done, 0);
      do_txn(vecs[2]);

      // ---- both requesters held high: starvation behaviour ----
      cyc();
      vid_req   = 1'b1;
      vid_addr  = 24'h000800;
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 24'h0000AA;
      #1;
      n_vid    = 0;
      host_won = 1'b0;
      stuck    = 1'b0;
      for (int b = 0; b < 6 + 2 * int'(MVR) && !host_won && !stuck; b++) begin
         cyc();
         mem_cmd_ready = 1'b1;
         #1;
         if (host_gnt) begin
            host_won = 1'b1;
            vid_req  = 1'b0;
         end else if (vid_gnt) begin
            n_vid++;
            feed_beats(1'b1, 8, 16'hF000, 1'b0);
`ifndef ARB_STARVE_GUARD_EN
            if (n_vid == 6) stuck = 1'b1;
`endif
         end else begin
            chk("guard_some_gnt", 0, 1);
            stuck = 1'b1;
         end
      end
`ifdef ARB_STARVE_GUARD_EN
      chk("guard_host_won", host_won, 1);
      chk("guard_vid_runs", n_vid, MVR);
      if (host_won) begin
         chk("guard_host_addr", mem_cmd_addr, 24'h0000AA);
         feed_beats(1'b0, 1, 16'h4321, 1'b1);
      end
`else
      chk("strict_no_host_gnt", host_won, 0);
      chk("strict_vid_runs",    n_vid, 6);
`endif
      vid_req       = 1'b0;
      host_req      = 1'b0;
      mem_cmd_ready = 1'b0;
      cyc();
      #1;
      cyc();
      #1;
      chk("end_cmd_valid", mem_cmd_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
